// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start edge-detected internally.
// Optional two's-complement operands are enabled with the SEQ_DIV_SIGNED_EN macro.
module seq_divider #(
    parameter int NBits   = 8,
    parameter int CntBits = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NBits-1:0] dividend,
    input  logic [NBits-1:0] divisor,
    output logic [NBits-1:0] quotient,
    output logic [NBits-1:0] remainder,
    output logic             readyBit,
    output logic             signBit,
    output logic             remSign,
    output logic             divByZero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         r_state;
    logic               r_start_d;
    logic [NBits-1:0]   r_q;
    logic [NBits-1:0]   r_d;
    logic [NBits-1:0]   r_r;
    logic [CntBits-1:0] r_cnt;

    logic               w_start_rise;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [NBits-1:0]   w_dvd_mag;
    logic [NBits-1:0]   w_dvs_mag;
    logic [NBits:0]     w_t;
    logic               w_ge;
    logic [NBits-1:0]   w_diff;
    logic [NBits-1:0]   w_r_next;
    logic [NBits-1:0]   w_q_next;

    assign w_start_rise = start & ~r_start_d;

`ifdef SEQ_DIV_SIGNED_EN
    assign w_dvd_neg = dividend[NBits-1];
    assign w_dvs_neg = divisor[NBits-1];
    // Negation wraps the most negative value onto its own unsigned magnitude.
    assign w_dvd_mag = w_dvd_neg ? ({NBits{1'b0}} - dividend) : dividend;
    assign w_dvs_mag = w_dvs_neg ? ({NBits{1'b0}} - divisor) : divisor;
`else
    assign w_dvd_neg = 1'b0;
    assign w_dvs_neg = 1'b0;
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
`endif

    // The partial remainder is always below D, so only NBits of R need storing;
    // the shifted value T keeps the extra bit for the compare.
    assign w_t      = {r_r, r_q[NBits-1]};
    assign w_ge     = (w_t >= {1'b0, r_d});
    assign w_diff   = w_t[NBits-1:0] - r_d;
    assign w_r_next = w_ge ? w_diff : w_t[NBits-1:0];
    assign w_q_next = {r_q[NBits-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_start_d <= 1'b0;
            r_q       <= '0;
            r_d       <= '0;
            r_r       <= '0;
            r_cnt     <= '0;
            quotient  <= '0;
            remainder <= '0;
            readyBit  <= 1'b0;
            signBit   <= 1'b0;
            remSign   <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            r_start_d <= start;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_rise) begin
                        signBit <= w_dvd_neg ^ w_dvs_neg;
                        remSign <= w_dvd_neg;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= w_dvd_mag;
                            divByZero <= 1'b1;
                            readyBit  <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_q       <= w_dvd_mag;
                            r_d       <= w_dvs_mag;
                            r_r       <= '0;
                            r_cnt     <= CntBits'(NBits);
                            readyBit  <= 1'b0;
                            divByZero <= 1'b0;
                            r_state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt - CntBits'(1);
                    if (r_cnt == CntBits'(1)) begin
                        quotient  <= w_q_next;
                        remainder <= w_r_next;
                        readyBit  <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, divide-by-zero, restart, ignored start and reset abort.
module tb_seq_divider;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       readyBit;
    logic       signBit;
    logic       remSign;
    logic       divByZero;

    int total = 0;
    int bad   = 0;

    seq_divider #(.NBits(8), .CntBits(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .readyBit  (readyBit),
        .signBit   (signBit),
        .remSign   (remSign),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise start after an edge; returns just after edge k, the one that samples the rise.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step(1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        step(2);
        reset = 1'b0;
        check("rst_q",   32'(quotient),  32'd0);
        check("rst_r",   32'(remainder), 32'd0);
        check("rst_rdy", 32'(readyBit),  32'd0);
        check("rst_sb",  32'(signBit),   32'd0);
        check("rst_rs",  32'(remSign),   32'd0);
        check("rst_dbz", 32'(divByZero), 32'd0);

        // 100/7
        start_op(8'd100, 8'd7);
        check("t1_rdy_k", 32'(readyBit), 32'd0);
        step(7);
        check("t1_rdy_k7", 32'(readyBit), 32'd0);
        step(1);
        check("t1_rdy", 32'(readyBit),  32'd1);
        check("t1_q",   32'(quotient),  32'd14);
        check("t1_r",   32'(remainder), 32'd2);
        check("t1_dbz", 32'(divByZero), 32'd0);
        check("t1_sb",  32'(signBit),   32'd0);
        start = 1'b0;
        step(1);

        // 55/0 completes on the accepting edge
        start_op(8'd55, 8'd0);
        check("t2_rdy",   32'(readyBit),    32'd1);
        check("t2_q",     32'(quotient),    32'hFF);
        check("t2_r",     32'(remainder),   32'd55);
        check("t2_dbz",   32'(divByZero),   32'd1);
        check("t2_state", 32'(dut.r_state), 32'd2);
        start = 1'b0;
        step(1);

        // 3/9 then restart from DONE with 255/1
        start_op(8'd3, 8'd9);
        check("t3a_dbz", 32'(divByZero), 32'd0);
        step(8);
        check("t3a_rdy", 32'(readyBit),  32'd1);
        check("t3a_q",   32'(quotient),  32'd0);
        check("t3a_r",   32'(remainder), 32'd3);
        start = 1'b0;
        step(1);
        start_op(8'd255, 8'd1);
        check("t3b_rdy_k", 32'(readyBit), 32'd0);
        step(8);
        check("t3b_rdy", 32'(readyBit),  32'd1);
        check("t3b_q",   32'(quotient),  32'd255);
        check("t3b_r",   32'(remainder), 32'd0);
        start = 1'b0;
        step(1);

        // 200/10 with an extra start pulse while busy
        start_op(8'd200, 8'd10);
        step(2);
        start = 1'b0;
        step(1);
        start = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        step(1);
        check("t4_rdy_busy", 32'(readyBit), 32'd0);
        step(3);
        check("t4_rdy_k7", 32'(readyBit), 32'd0);
        step(1);
        check("t4_rdy", 32'(readyBit),  32'd1);
        check("t4_q",   32'(quotient),  32'd20);
        check("t4_r",   32'(remainder), 32'd0);
        step(2);
        check("t4_hold_rdy", 32'(readyBit), 32'd1);
        check("t4_hold_q",   32'(quotient), 32'd20);
        start = 1'b0;
        step(1);

        // reset during iteration 4 of 100/7
        start_op(8'd100, 8'd7);
        step(3);
        reset = 1'b1;
        start = 1'b0;
        step(1);
        reset = 1'b0;
        check("t5_q",     32'(quotient),    32'd0);
        check("t5_r",     32'(remainder),   32'd0);
        check("t5_rdy",   32'(readyBit),    32'd0);
        check("t5_dbz",   32'(divByZero),   32'd0);
        check("t5_state", 32'(dut.r_state), 32'd0);
        step(1);
        check("t5_idle_rdy", 32'(readyBit), 32'd0);
        start_op(8'd100, 8'd7);
        step(8);
        check("t5b_rdy", 32'(readyBit),  32'd1);
        check("t5b_q",   32'(quotient),  32'd14);
        check("t5b_r",   32'(remainder), 32'd2);
        start = 1'b0;
        step(1);

`ifdef SEQ_DIV_SIGNED_EN
        start_op(8'h9C, 8'd7);
        step(8);
        check("t6a_q",  32'(quotient),  32'd14);
        check("t6a_r",  32'(remainder), 32'd2);
        check("t6a_sb", 32'(signBit),   32'd1);
        check("t6a_rs", 32'(remSign),   32'd1);
        start = 1'b0;
        step(1);
        start_op(8'h80, 8'hFF);
        step(8);
        check("t6b_q",  32'(quotient),  32'd128);
        check("t6b_r",  32'(remainder), 32'd0);
        check("t6b_sb", 32'(signBit),   32'd0);
        check("t6b_rs", 32'(remSign),   32'd1);
        start = 1'b0;
        step(1);
`else
        // 156/7 = 22 r 2 ; 128/255 = 0 r 128, both treated as unsigned
        start_op(8'h9C, 8'd7);
        step(8);
        check("u6a_q",  32'(quotient),  32'd22);
        check("u6a_r",  32'(remainder), 32'd2);
        check("u6a_sb", 32'(signBit),   32'd0);
        check("u6a_rs", 32'(remSign),   32'd0);
        start = 1'b0;
        step(1);
        start_op(8'h80, 8'hFF);
        step(8);
        check("u6b_q",  32'(quotient),  32'd0);
        check("u6b_r",  32'(remainder), 32'd128);
        check("u6b_sb", 32'(signBit),   32'd0);
        start = 1'b0;
        step(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
